// File: rtl/stk_pkg.sv
// Shared stack SRAM geometry, command encoding and controller types.
// Used by stk_ctrl and its sub-blocks; see stk_ctrl.sv for STK_CTRL_OCC_EN.
package stk_pkg;

  localparam int BANKS_N        = 2;
  localparam int C_BANK_LINES_N = 4;
  localparam int PTR_W          = 3;
  localparam int ENGID_W        = 2;
  localparam int ENG_N          = 1 << ENGID_W;
  localparam int OPCODE_W       = 2;
  localparam int DAT_W          = 32;

  typedef logic [PTR_W-1:0]   ptr_t;
  typedef logic [PTR_W:0]     cnt_t;
  typedef logic [ENGID_W-1:0] engid_t;

  typedef enum logic [OPCODE_W-1:0] {
    OP_NOP  = 2'd0,
    OP_PUSH = 2'd1,
    OP_POP  = 2'd2,
    OP_INV  = 2'd3
  } opcode_t;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_EXEC
  } stk_ctrl_state_t;

  // Line layout at the default data width: payload in the MSBs, link in the LSBs.
  typedef struct packed {
    logic [DAT_W-1:0] dat;
    ptr_t             nxt;
  } line_t;

  function automatic ptr_t ptr_wrap_inc(input ptr_t p, input int unsigned lines_n);
    return (p == ptr_t'(lines_n - 1)) ? '0 : p + ptr_t'(1);
  endfunction

endpackage

// File: rtl/stk_ctrl_if.sv
// Command/response handshake plus single-port SRAM bus of the stack controller.
// slave = controller view, master = arbiter + SRAM view.
interface stk_ctrl_if #(parameter int W = 32);
  import stk_pkg::*;

  logic                 cmd_vld;
  logic                 cmd_rdy;
  opcode_t              cmd_opcode;
  engid_t               cmd_engid;
  logic [W-1:0]         cmd_dat;

  logic                 rsp_vld;
  engid_t               rsp_engid;
  logic [W-1:0]         rsp_dat;
  logic                 rsp_err;

  logic                 mem_en;
  logic                 mem_wen;
  ptr_t                 mem_addr;
  logic [W+PTR_W-1:0]   mem_wdat;
  logic [W+PTR_W-1:0]   mem_rdat;

  modport slave (
    input  cmd_vld, cmd_opcode, cmd_engid, cmd_dat, mem_rdat,
    output cmd_rdy, rsp_vld, rsp_engid, rsp_dat, rsp_err,
           mem_en, mem_wen, mem_addr, mem_wdat
  );

  modport master (
    output cmd_vld, cmd_opcode, cmd_engid, cmd_dat, mem_rdat,
    input  cmd_rdy, rsp_vld, rsp_engid, rsp_dat, rsp_err,
           mem_en, mem_wen, mem_addr, mem_wdat
  );

endinterface

// File: rtl/stk_ctrl_tbl.sv
// Per-engine stack head/count register file: one async read port, one write port.
// STK_CTRL_OCC_EN adds a count-only observation port.
module stk_ctrl_tbl
  import stk_pkg::*;
(
  input  logic   clk,
  input  logic   arst,
  input  engid_t rd_eng,
  output ptr_t   rd_head,
  output cnt_t   rd_cnt,
  input  logic   wr_en,
  input  engid_t wr_eng,
  input  ptr_t   wr_head,
  input  cnt_t   wr_cnt
`ifdef STK_CTRL_OCC_EN
  ,
  input  engid_t occ_eng,
  output cnt_t   occ_cnt
`endif
);

  ptr_t head [ENG_N];
  cnt_t cnt  [ENG_N];

  // NOTE: this array is small and its counts define stack emptiness, so every
  // entry is reset; large data memories should not be reset this way.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int i = 0; i < ENG_N; i++) begin
        head[i] <= '0;
        cnt[i]  <= '0;
      end
    end else if (wr_en) begin
      head[wr_eng] <= wr_head;
      cnt[wr_eng]  <= wr_cnt;
    end
  end

  assign rd_head = head[rd_eng];
  assign rd_cnt  = cnt[rd_eng];

`ifdef STK_CTRL_OCC_EN
  assign occ_cnt = cnt[occ_eng];
`endif

endmodule

// File: rtl/stk_ctrl.sv
// Linked-list LIFO per engine plus a hardware free list in one single-port SRAM.
// Optional STK_CTRL_OCC_EN exposes per-engine occupancy and the free count.
module stk_ctrl
  import stk_pkg::*;
#(
  parameter int W       = 32,
  parameter int LINES_N = BANKS_N * C_BANK_LINES_N
) (
  input  logic        clk,
  input  logic        arst,
  stk_ctrl_if.slave   bus
`ifdef STK_CTRL_OCC_EN
  ,
  input  engid_t      occ_engid,
  output cnt_t        occ_cnt,
  output cnt_t        free_cnt_o
`endif
);

  typedef struct packed {
    logic [W-1:0] dat;
    ptr_t         nxt;
  } mline_t;

  stk_ctrl_state_t state;
  ptr_t            init_idx;
  ptr_t            free_hd;
  cnt_t            free_cnt;
  opcode_t         op_q;
  engid_t          eng_q;
  logic [W-1:0]    dat_q;

  logic            rdy;
  logic            rsp_vld;
  logic            rsp_err;
  engid_t          rsp_engid;
  logic [W-1:0]    rsp_dat;

  engid_t          rd_eng;
  ptr_t            rd_head;
  cnt_t            rd_cnt;
  logic            wr_en;
  ptr_t            wr_head;
  cnt_t            wr_cnt;

  logic            hs;
  logic            cmd_ok;
  logic            mem_en;
  logic            mem_wen;
  ptr_t            mem_addr;
  mline_t          wline;
  mline_t          rdat;

  assign rdat = mline_t'(bus.mem_rdat);
  assign hs   = bus.cmd_vld & rdy;

  stk_ctrl_tbl u_tbl (
    .clk     (clk),
    .arst    (arst),
    .rd_eng  (rd_eng),
    .rd_head (rd_head),
    .rd_cnt  (rd_cnt),
    .wr_en   (wr_en),
    .wr_eng  (eng_q),
    .wr_head (wr_head),
    .wr_cnt  (wr_cnt)
`ifdef STK_CTRL_OCC_EN
    ,
    .occ_eng (occ_engid),
    .occ_cnt (occ_cnt)
`endif
  );

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    rd_eng  = (state == ST_EXEC) ? eng_q : bus.cmd_engid;
    cmd_ok  = 1'b0;
    case (bus.cmd_opcode)
      OP_PUSH: cmd_ok = (free_cnt != '0);
      OP_POP:  cmd_ok = (rd_cnt != '0);
      default: cmd_ok = 1'b0;
    endcase

    wr_en   = (state == ST_EXEC);
    wr_head = (op_q == OP_PUSH) ? free_hd : rdat.nxt;
    wr_cnt  = (op_q == OP_PUSH) ? rd_cnt + cnt_t'(1) : rd_cnt - cnt_t'(1);
  end

  // SRAM port: INIT links the free list, IDLE issues the read, EXEC writes back.
  always_comb begin
    mem_en   = 1'b0;
    mem_wen  = 1'b0;
    mem_addr = '0;
    wline    = '0;
    case (state)
      ST_INIT: begin
        mem_en    = 1'b1;
        mem_wen   = 1'b1;
        mem_addr  = init_idx;
        wline.nxt = ptr_wrap_inc(init_idx, LINES_N);
      end
      ST_IDLE: begin
        if (hs && cmd_ok) begin
          mem_en   = 1'b1;
          mem_addr = (bus.cmd_opcode == OP_PUSH) ? free_hd : rd_head;
        end
      end
      ST_EXEC: begin
        mem_en  = 1'b1;
        mem_wen = 1'b1;
        if (op_q == OP_PUSH) begin
          mem_addr  = free_hd;
          wline.dat = dat_q;
          wline.nxt = rd_head;
        end else begin
          mem_addr  = rd_head;
          wline.nxt = free_hd;
        end
      end
      default: ;
    endcase
  end

  // Strobes are held off while reset is asserted even though the FSM sits in INIT.
  assign bus.mem_en   = mem_en & ~arst;
  assign bus.mem_wen  = mem_wen & ~arst;
  assign bus.mem_addr = mem_addr;
  assign bus.mem_wdat = wline;

  // NOTE: all state here is sequential and uses non-blocking assignments so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state     <= ST_INIT;
      init_idx  <= '0;
      free_hd   <= '0;
      free_cnt  <= '0;
      op_q      <= OP_NOP;
      eng_q     <= '0;
      dat_q     <= '0;
      rdy       <= 1'b0;
      rsp_vld   <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_engid <= '0;
      rsp_dat   <= '0;
    end else begin
      rsp_vld <= 1'b0;
      rsp_err <= 1'b0;
      rsp_dat <= '0;
      case (state)
        ST_INIT: begin
          if (init_idx == ptr_t'(LINES_N - 1)) begin
            free_hd  <= '0;
            free_cnt <= cnt_t'(LINES_N);
            rdy      <= 1'b1;
            state    <= ST_IDLE;
          end else begin
            init_idx <= init_idx + ptr_t'(1);
          end
        end
        ST_IDLE: begin
          if (hs) begin
            if (cmd_ok) begin
              op_q  <= bus.cmd_opcode;
              eng_q <= bus.cmd_engid;
              dat_q <= bus.cmd_dat;
              rdy   <= 1'b0;
              state <= ST_EXEC;
            end else if (bus.cmd_opcode != OP_NOP) begin
              rsp_vld   <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_engid <= bus.cmd_engid;
            end
          end
        end
        ST_EXEC: begin
          if (op_q == OP_PUSH) begin
            free_hd  <= rdat.nxt;
            free_cnt <= free_cnt - cnt_t'(1);
          end else begin
            free_hd  <= rd_head;
            free_cnt <= free_cnt + cnt_t'(1);
            rsp_dat  <= rdat.dat;
          end
          rsp_vld   <= 1'b1;
          rsp_engid <= eng_q;
          rdy       <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  assign bus.cmd_rdy   = rdy;
  assign bus.rsp_vld   = rsp_vld;
  assign bus.rsp_err   = rsp_err;
  assign bus.rsp_engid = rsp_engid;
  assign bus.rsp_dat   = rsp_dat;

`ifdef STK_CTRL_OCC_EN
  assign free_cnt_o = free_cnt;
`endif

endmodule
